// File: rtl/matmul_apb_seq_checker_if.sv
// APB bus between the matmul sequence checker (master) and the matmul IP slave port.
interface matmul_apb_seq_checker_if #(
    parameter int unsigned ADDR_W = 12
);
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [31:0]       pwdata;
    logic [31:0]       prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/matmul_apb_seq_checker.sv
// APB master that loads A and B into the matmul IP, starts it, polls for completion and
// checks every C element against golden words from a source memory.
module matmul_apb_seq_checker #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned ACC_W      = 32,
    parameter int unsigned M          = 4,
    parameter int unsigned K          = 4,
    parameter int unsigned N          = 4,
    parameter int unsigned ADDR_W     = 12,
    parameter int unsigned A_BASE     = 'h000,
    parameter int unsigned B_BASE     = 'h100,
    parameter int unsigned C_BASE     = 'h200,
    parameter int unsigned CTRL_ADDR  = 'hF00,
    parameter int unsigned STAT_ADDR  = 'hF04,
    parameter int unsigned POLL_LIMIT = 1024,
    parameter int unsigned SRC_AW     = 10
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    output logic [SRC_AW-1:0]        src_addr_o,
    input  logic [31:0]              src_rdata_i,
    matmul_apb_seq_checker_if.master apb,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     pass_o,
    output logic [15:0]              mismatch_cnt_o,
    output logic [7:0]               slverr_cnt_o,
    output logic                     timeout_o
);
    localparam int unsigned MK    = M * K;
    localparam int unsigned KN    = K * N;
    localparam int unsigned MN    = M * N;
    localparam int unsigned MAX_E = (MK > KN) ? ((MK > MN) ? MK : MN) : ((KN > MN) ? KN : MN);
    localparam int unsigned IDX_W = $clog2(MAX_E + 1);
    localparam int unsigned PC_W  = $clog2(POLL_LIMIT + 1);

    typedef enum logic [2:0] {
        PhIdle, PhLoadA, PhLoadB, PhStart, PhPoll, PhReadC, PhDone
    } phase_e;
    typedef enum logic [1:0] {XFetch, XSetup, XAccess, XGap} xfer_e;

    phase_e             phase_q, phase_d;
    xfer_e              xfer_q, xfer_d;
    logic [IDX_W-1:0]   idx_q, idx_d, last_idx;
    logic [PC_W-1:0]    poll_q, poll_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [ACC_W-1:0]   golden_q, golden_d;
    logic [15:0]        mism_q, mism_d;
    logic [7:0]         serr_q, serr_d;
    logic               timeout_q, timeout_d, pass_q, pass_d;
    logic               beat_done, last_elem, run_ok;
    logic [ADDR_W-1:0]  elem_off;

    assign apb.psel    = (xfer_q == XSetup) || (xfer_q == XAccess);
    assign apb.penable = (xfer_q == XAccess);
    assign apb.pwdata  = wdata_q;
    assign apb.pwrite  = apb.psel &&
                         (phase_q == PhLoadA || phase_q == PhLoadB || phase_q == PhStart);
    assign beat_done   = apb.penable && apb.pready;
    assign elem_off    = ADDR_W'({idx_q, 2'b00});
    assign last_elem   = (idx_q == last_idx);
    assign run_ok      = (mism_q == 16'd0) && (serr_q == 8'd0) && !timeout_q;

    assign busy_o         = (phase_q != PhIdle) && (phase_q != PhDone);
    assign done_o         = (phase_q == PhDone);
    assign pass_o         = done_o ? run_ok : pass_q;
    assign mismatch_cnt_o = mism_q;
    assign slverr_cnt_o   = serr_q;
    assign timeout_o      = timeout_q;

    always_comb begin
        last_idx   = IDX_W'(MN - 1);
        src_addr_o = '0;
        apb.paddr  = '0;
        case (phase_q)
            PhLoadA: begin
                last_idx   = IDX_W'(MK - 1);
                src_addr_o = SRC_AW'(idx_q);
            end
            PhLoadB: begin
                last_idx   = IDX_W'(KN - 1);
                src_addr_o = SRC_AW'(MK) + SRC_AW'(idx_q);
            end
            PhReadC: src_addr_o = SRC_AW'(MK + KN) + SRC_AW'(idx_q);
            default: ;
        endcase
        if (apb.psel) begin
            case (phase_q)
                PhLoadA: apb.paddr = ADDR_W'(A_BASE) + elem_off;
                PhLoadB: apb.paddr = ADDR_W'(B_BASE) + elem_off;
                PhReadC: apb.paddr = ADDR_W'(C_BASE) + elem_off;
                PhStart: apb.paddr = ADDR_W'(CTRL_ADDR);
                PhPoll:  apb.paddr = ADDR_W'(STAT_ADDR);
                default: ;
            endcase
        end
    end

    always_comb begin
        phase_d   = phase_q;
        xfer_d    = xfer_q;
        idx_d     = idx_q;
        poll_d    = poll_q;
        wdata_d   = wdata_q;
        golden_d  = golden_q;
        mism_d    = mism_q;
        serr_d    = serr_q;
        timeout_d = timeout_q;
        pass_d    = pass_q;

        if (beat_done && apb.pslverr && serr_q != 8'hFF) serr_d = serr_q + 8'd1;

        case (phase_q)
            PhIdle: begin
                if (start_i) begin
                    phase_d   = PhLoadA;
                    xfer_d    = XFetch;
                    idx_d     = '0;
                    mism_d    = '0;
                    serr_d    = '0;
                    timeout_d = 1'b0;
                end
            end
            PhLoadA, PhLoadB, PhReadC: begin
                case (xfer_q)
                    XFetch: begin
                        xfer_d = XSetup;
                        if (phase_q == PhReadC) golden_d = src_rdata_i[ACC_W-1:0];
                        else                    wdata_d  = 32'(src_rdata_i[DATA_W-1:0]);
                    end
                    XSetup: xfer_d = XAccess;
                    XAccess: begin
                        if (apb.pready) begin
                            if (phase_q == PhReadC && apb.prdata[ACC_W-1:0] != golden_q &&
                                mism_q != 16'hFFFF) begin
                                mism_d = mism_q + 16'd1;
                            end
                            xfer_d = XFetch;
                            idx_d  = idx_q + IDX_W'(1);
                            if (last_elem) begin
                                idx_d = '0;
                                if (phase_q == PhLoadA) begin
                                    phase_d = PhLoadB;
                                end else if (phase_q == PhLoadB) begin
                                    // CTRL write follows immediately, no source fetch
                                    phase_d = PhStart;
                                    xfer_d  = XSetup;
                                    wdata_d = 32'h1;
                                end else begin
                                    phase_d = PhDone;
                                end
                            end
                        end
                    end
                    default: xfer_d = XFetch;
                endcase
            end
            PhStart: begin
                case (xfer_q)
                    XSetup:  xfer_d = XAccess;
                    XAccess: begin
                        if (apb.pready) begin
                            phase_d = PhPoll;
                            xfer_d  = XSetup;
                            poll_d  = '0;
                        end
                    end
                    default: xfer_d = XSetup;
                endcase
            end
            PhPoll: begin
                case (xfer_q)
                    XSetup:  xfer_d = XAccess;
                    XAccess: begin
                        if (apb.pready) begin
                            poll_d = poll_q + PC_W'(1);
                            if (apb.prdata[0]) begin
                                phase_d = PhReadC;
                                xfer_d  = XFetch;
                                idx_d   = '0;
                            end else if (poll_q == PC_W'(POLL_LIMIT - 1)) begin
                                timeout_d = 1'b1;
                                phase_d   = PhDone;
                                xfer_d    = XFetch;
                            end else begin
                                xfer_d = XGap;
                            end
                        end
                    end
                    default: xfer_d = XSetup;  // one idle cycle between status reads
                endcase
            end
            PhDone: begin
                phase_d = PhIdle;
                xfer_d  = XFetch;
                pass_d  = run_ok;
            end
            default: begin
                phase_d = PhIdle;
                xfer_d  = XFetch;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            phase_q   <= PhIdle;
            xfer_q    <= XFetch;
            idx_q     <= '0;
            poll_q    <= '0;
            wdata_q   <= '0;
            golden_q  <= '0;
            mism_q    <= '0;
            serr_q    <= '0;
            timeout_q <= 1'b0;
            pass_q    <= 1'b0;
        end else begin
            phase_q   <= phase_d;
            xfer_q    <= xfer_d;
            idx_q     <= idx_d;
            poll_q    <= poll_d;
            wdata_q   <= wdata_d;
            golden_q  <= golden_d;
            mism_q    <= mism_d;
            serr_q    <= serr_d;
            timeout_q <= timeout_d;
            pass_q    <= pass_d;
        end
    end
endmodule
